// File: rtl/vid_mosaic_pkg.sv
// Shared encodings and slot-packing helper for the RGB/YUV mosaic repacker.
package vid_mosaic_pkg;

  typedef enum logic [1:0] {
    MODE_ORIG   = 2'd0,
    MODE_YUV422 = 2'd1,
    MODE_RAW    = 2'd2,
    MODE_ORIG_B = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    PAT_RGGB = 2'd0,
    PAT_GRBG = 2'd1,
    PAT_GBRG = 2'd2,
    PAT_BGGR = 2'd3
  } pattern_e;

  // Left-aligns a component inside its slot; caller truncates to slot width.
  function automatic logic [31:0] pack_slot(input logic [31:0] v, input int unsigned pad);
    return v << pad;
  endfunction

endpackage

// File: rtl/vid_edge_det.sv
// Registered edge detector: lvl is the input delayed one cycle, rise/fall flag edges aligned with lvl.
module vid_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic lvl,
  output logic rise,
  output logic fall
);

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      lvl  <= sig;
      rise <= sig & ~lvl;
      fall <= ~sig & lvl;
    end
  end

endmodule

// File: rtl/vid_rgb_mosaic_v2.sv
// Repacks C_PORT_NUM pixels/clock into pass-through, YUV422 or Bayer RAW layout.
// Two-stage pipeline: stage 1 registers inputs and edges, stage 2 forms output data.
module vid_rgb_mosaic_v2
  import vid_mosaic_pkg::*;
#(
  parameter int C_PORT_NUM            = 4,
  parameter int C_BITS_IN             = 8,
  parameter int C_BITS_PER_CPNT       = 12,
  parameter int C_MAX_CPNTS_PER_PIXEL = 3
) (
  input  logic                                                      VID_CLK,
  input  logic                                                      VID_RST,
  input  logic                                                      S_VS,
  input  logic                                                      S_HS,
  input  logic                                                      S_DE,
  input  logic [C_BITS_IN*C_PORT_NUM-1:0]                           S_R_Y,
  input  logic [C_BITS_IN*C_PORT_NUM-1:0]                           S_G_U,
  input  logic [C_BITS_IN*C_PORT_NUM-1:0]                           S_B_V,
  input  logic [1:0]                                                TRANSFER_MODE,
  input  logic [1:0]                                                BAYER_PATTERN,
  output logic                                                      M_VS,
  output logic                                                      M_HS,
  output logic                                                      M_DE,
  output logic [C_BITS_PER_CPNT*C_MAX_CPNTS_PER_PIXEL*C_PORT_NUM-1:0] M_VID_DATA,
  output logic [3:0]                                                M_MODE_ACT
);

  localparam int          IN_W     = C_BITS_IN * C_PORT_NUM;
  localparam int          PIX_W    = C_BITS_PER_CPNT * C_MAX_CPNTS_PER_PIXEL;
  localparam int          OUT_W    = PIX_W * C_PORT_NUM;
  localparam int unsigned PAD      = C_BITS_PER_CPNT - C_BITS_IN;
  localparam logic        PORT_ODD = (C_PORT_NUM % 2) != 0;

  logic            vs_p1, vs_rise_p1, unused_vs_fall;
  logic            de_p1, de_rise_p1, de_fall_p1;
  logic            hs_p1;
  logic [IN_W-1:0] r_p1, g_p1, b_p1;
  logic [1:0]      tm_p1, bp_p1;

  logic                 lp_q, cph_q;
  logic [1:0]           mode_q, pat_q;
  logic [C_BITS_IN-1:0] vlast_q;

  logic                 lp_cur, cph_cur;
  logic [1:0]           mode_cur, pat_cur;
  logic [OUT_W-1:0]     data_nxt;

  logic             vs_p2, hs_p2, de_p2;
  logic [3:0]       mode_act_p2;
  logic [OUT_W-1:0] data_p2;

  // ---- stage 1: input registers and sync edges ----
  vid_edge_det u_vs_edge (
    .clk (VID_CLK), .rst (VID_RST), .sig (S_VS),
    .lvl (vs_p1), .rise (vs_rise_p1), .fall (unused_vs_fall)
  );

  vid_edge_det u_de_edge (
    .clk (VID_CLK), .rst (VID_RST), .sig (S_DE),
    .lvl (de_p1), .rise (de_rise_p1), .fall (de_fall_p1)
  );

  always_ff @(posedge VID_CLK) begin
    if (VID_RST) begin
      hs_p1 <= 1'b0;
      r_p1  <= '0;
      g_p1  <= '0;
      b_p1  <= '0;
      tm_p1 <= '0;
      bp_p1 <= '0;
    end else begin
      hs_p1 <= S_HS;
      r_p1  <= S_R_Y;
      g_p1  <= S_G_U;
      b_p1  <= S_B_V;
      tm_p1 <= TRANSFER_MODE;
      bp_p1 <= BAYER_PATTERN;
    end
  end

  // A VS rise takes priority over a coincident DE fall, leaving lp at 0.
  always_comb begin
    lp_cur   = vs_rise_p1 ? 1'b0  : lp_q;
    cph_cur  = de_rise_p1 ? 1'b0  : cph_q;
    mode_cur = vs_rise_p1 ? tm_p1 : mode_q;
    pat_cur  = vs_rise_p1 ? bp_p1 : pat_q;
  end

  always_ff @(posedge VID_CLK) begin
    if (VID_RST) begin
      lp_q    <= 1'b0;
      cph_q   <= 1'b0;
      mode_q  <= '0;
      pat_q   <= '0;
      vlast_q <= '0;
    end else begin
      mode_q <= mode_cur;
      pat_q  <= pat_cur;
      if (vs_rise_p1)      lp_q <= 1'b0;
      else if (de_fall_p1) lp_q <= ~lp_q;
      if (de_p1) begin
        cph_q   <= cph_cur ^ PORT_ODD;
        vlast_q <= b_p1[IN_W-1 -: C_BITS_IN];
      end
    end
  end

  // ---- stage 2: layout formation ----
  always_comb begin
    logic [IN_W+C_BITS_IN-1:0] v_ext;
    logic [C_BITS_IN-1:0]      rv, gv, bv, prev_v;
    logic [C_BITS_IN-1:0]      sv [3];
    logic                      cp, l, c;
    data_nxt = '0;
    v_ext    = {b_p1, vlast_q};
    rv = '0; gv = '0; bv = '0; prev_v = '0;
    sv = '{default: '0};
    cp = 1'b0; l = 1'b0; c = 1'b0;
    for (int i = 0; i < C_PORT_NUM; i++) begin
      rv     = r_p1[C_BITS_IN*i +: C_BITS_IN];
      gv     = g_p1[C_BITS_IN*i +: C_BITS_IN];
      bv     = b_p1[C_BITS_IN*i +: C_BITS_IN];
      prev_v = v_ext[C_BITS_IN*i +: C_BITS_IN];
      cp     = cph_cur ^ i[0];
      sv     = '{default: '0};
      case (mode_cur)
        MODE_YUV422: begin
          sv[0] = rv;
          sv[1] = cp ? prev_v : gv;
        end
        MODE_RAW: begin
          l = lp_cur ^ pat_cur[1];
          c = cp ^ pat_cur[0];
          if (!l && !c)     sv[0] = rv;
          else if (l && c)  sv[0] = bv;
          else              sv[0] = gv;
        end
        default: begin
          sv[0] = rv;
          sv[1] = gv;
          sv[2] = bv;
        end
      endcase
      for (int j = 0; j < 3; j++) begin
        if (j < C_MAX_CPNTS_PER_PIXEL)
          data_nxt[PIX_W*i + C_BITS_PER_CPNT*j +: C_BITS_PER_CPNT] =
            C_BITS_PER_CPNT'(pack_slot(32'(sv[j]), PAD));
      end
    end
    if (!de_p1) data_nxt = '0;
  end

  always_ff @(posedge VID_CLK) begin
    if (VID_RST) begin
      vs_p2       <= 1'b0;
      hs_p2       <= 1'b0;
      de_p2       <= 1'b0;
      mode_act_p2 <= '0;
      data_p2     <= '0;
    end else begin
      vs_p2       <= vs_p1;
      hs_p2       <= hs_p1;
      de_p2       <= de_p1;
      mode_act_p2 <= {pat_cur, mode_cur};
      data_p2     <= data_nxt;
    end
  end

  assign M_VS       = vs_p2;
  assign M_HS       = hs_p2;
  assign M_DE       = de_p2;
  assign M_VID_DATA = data_p2;
  assign M_MODE_ACT = mode_act_p2;

endmodule

// File: tb/tb_vid_rgb_mosaic_v2.sv
// Bench for vid_rgb_mosaic_v2: 4-port and 3-port instances driven by shared directed stimulus.
module tb_vid_rgb_mosaic_v2;

  localparam int PW = 36;
  localparam logic [35:0] PR   = 36'h000000110;
  localparam logic [35:0] PG   = 36'h000000220;
  localparam logic [35:0] PB   = 36'h000000330;
  localparam logic [35:0] PORG = 36'h330220110;

  typedef struct packed {
    logic         vs;
    logic         hs;
    logic         de;
    logic [3:0]   mact;
    logic [143:0] data;
  } out_t;

  logic clk = 1'b0;
  logic rst;
  logic s_vs, s_hs, s_de;
  logic [1:0] tm, bp;
  logic [7:0] r_px [4];
  logic [7:0] g_px [4];
  logic [7:0] b_px [4];
  logic [31:0] s_r4, s_g4, s_b4;
  logic [23:0] s_r3, s_g3, s_b3;

  logic         m_vs4, m_hs4, m_de4, m_vs3, m_hs3, m_de3;
  logic [143:0] m_data4;
  logic [107:0] m_data3;
  logic [3:0]   m_mact4, m_mact3;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [35:0] cap4 [$];
  logic [35:0] cap3 [$];
  logic [35:0] want [$];

  logic       pvs [2];
  logic       pde [2];
  logic       lp  [2];
  int         kb  [2];
  logic [1:0] md  [2];
  logic [1:0] pt  [2];
  logic [7:0] vlast [2];
  out_t       st1 [2];
  out_t       oexp [2];

  assign s_r4 = {r_px[3], r_px[2], r_px[1], r_px[0]};
  assign s_g4 = {g_px[3], g_px[2], g_px[1], g_px[0]};
  assign s_b4 = {b_px[3], b_px[2], b_px[1], b_px[0]};
  assign s_r3 = {r_px[2], r_px[1], r_px[0]};
  assign s_g3 = {g_px[2], g_px[1], g_px[0]};
  assign s_b3 = {b_px[2], b_px[1], b_px[0]};

  vid_rgb_mosaic_v2 #(.C_PORT_NUM(4), .C_BITS_IN(8), .C_BITS_PER_CPNT(12), .C_MAX_CPNTS_PER_PIXEL(3)) dut4 (
    .VID_CLK(clk), .VID_RST(rst), .S_VS(s_vs), .S_HS(s_hs), .S_DE(s_de),
    .S_R_Y(s_r4), .S_G_U(s_g4), .S_B_V(s_b4), .TRANSFER_MODE(tm), .BAYER_PATTERN(bp),
    .M_VS(m_vs4), .M_HS(m_hs4), .M_DE(m_de4), .M_VID_DATA(m_data4), .M_MODE_ACT(m_mact4)
  );

  vid_rgb_mosaic_v2 #(.C_PORT_NUM(3), .C_BITS_IN(8), .C_BITS_PER_CPNT(12), .C_MAX_CPNTS_PER_PIXEL(3)) dut3 (
    .VID_CLK(clk), .VID_RST(rst), .S_VS(s_vs), .S_HS(s_hs), .S_DE(s_de),
    .S_R_Y(s_r3), .S_G_U(s_g3), .S_B_V(s_b3), .TRANSFER_MODE(tm), .BAYER_PATTERN(bp),
    .M_VS(m_vs3), .M_HS(m_hs3), .M_DE(m_de3), .M_VID_DATA(m_data3), .M_MODE_ACT(m_mact3)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] slot(input logic [7:0] v);
    return {v, 4'h0};
  endfunction

  // Colour filter tables: 0=R, 1=G, 2=B, indexed by row*2+col.
  function automatic int cfa(input logic [1:0] p, input logic l, input int c);
    int t [4];
    case (p)
      2'd0:    t = '{0, 1, 1, 2};
      2'd1:    t = '{1, 0, 2, 1};
      2'd2:    t = '{1, 2, 0, 1};
      default: t = '{2, 1, 1, 0};
    endcase
    return t[int'(l) * 2 + c];
  endfunction

  task automatic model_step(input int m, input int n);
    out_t e;
    logic vs_r, de_r, de_f;
    logic [7:0] s0, s1, s2, prev_v;
    int col, colr;
    if (rst) begin
      pvs[m] = 0; pde[m] = 0; lp[m] = 0; kb[m] = 0;
      md[m] = 0; pt[m] = 0; vlast[m] = 0;
      st1[m] = '0; oexp[m] = '0;
      return;
    end
    e = '0;
    vs_r = s_vs & ~pvs[m];
    de_r = s_de & ~pde[m];
    de_f = ~s_de & pde[m];
    if (vs_r) begin
      md[m] = tm; pt[m] = bp; lp[m] = 1'b0;
    end
    if (de_r) kb[m] = 0;
    e.vs = s_vs; e.hs = s_hs; e.de = s_de;
    e.mact = {pt[m], md[m]};
    if (s_de) begin
      for (int i = 0; i < n; i++) begin
        if (i == 0) prev_v = vlast[m];
        else        prev_v = b_px[i-1];
        col = kb[m] * n + i;
        s0 = 8'h0; s1 = 8'h0; s2 = 8'h0;
        case (md[m])
          2'd1: begin
            s0 = r_px[i];
            s1 = (col % 2 == 0) ? g_px[i] : prev_v;
          end
          2'd2: begin
            colr = cfa(pt[m], lp[m], col % 2);
            s0 = (colr == 0) ? r_px[i] : (colr == 1) ? g_px[i] : b_px[i];
          end
          default: begin
            s0 = r_px[i]; s1 = g_px[i]; s2 = b_px[i];
          end
        endcase
        e.data[PW*i +: PW] = {slot(s2), slot(s1), slot(s0)};
      end
      kb[m] = kb[m] + 1;
      vlast[m] = b_px[n-1];
    end
    if (de_f && !vs_r) lp[m] = ~lp[m];
    pvs[m] = s_vs;
    pde[m] = s_de;
    oexp[m] = st1[m];
    st1[m] = e;
  endtask

  always @(posedge clk) begin
    model_step(0, 4);
    model_step(1, 3);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({m_vs4, m_hs4, m_de4, m_mact4, m_data4} !== oexp[0]) begin
        errors++;
        $display("FAIL model_dut4 t=%0t got vs%b hs%b de%b mode%h data%h want vs%b hs%b de%b mode%h data%h",
                 $time, m_vs4, m_hs4, m_de4, m_mact4, m_data4,
                 oexp[0].vs, oexp[0].hs, oexp[0].de, oexp[0].mact, oexp[0].data);
      end
      checks++;
      if ({m_vs3, m_hs3, m_de3, m_mact3, 36'h0, m_data3} !== oexp[1]) begin
        errors++;
        $display("FAIL model_dut3 t=%0t got vs%b hs%b de%b mode%h data%h want vs%b hs%b de%b mode%h data%h",
                 $time, m_vs3, m_hs3, m_de3, m_mact3, m_data3,
                 oexp[1].vs, oexp[1].hs, oexp[1].de, oexp[1].mact, oexp[1].data[107:0]);
      end
      if (m_de4) for (int i = 0; i < 4; i++) cap4.push_back(m_data4[PW*i +: PW]);
      if (m_de3) for (int i = 0; i < 3; i++) cap3.push_back(m_data3[PW*i +: PW]);
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic compare_cap(input string nm, input bit sel3);
    int got_n;
    got_n = sel3 ? cap3.size() : cap4.size();
    check({nm, "_count"}, 64'(got_n), 64'(want.size()));
    for (int i = 0; i < want.size() && i < got_n; i++)
      check($sformatf("%s_px%0d", nm, i), sel3 ? 64'(cap3[i]) : 64'(cap4[i]), 64'(want[i]));
    cap4.delete();
    cap3.delete();
  endtask

  task automatic step(input logic vs, input logic hs, input logic de);
    s_vs = vs; s_hs = hs; s_de = de;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_const();
    for (int i = 0; i < 4; i++) begin
      r_px[i] = 8'h11; g_px[i] = 8'h22; b_px[i] = 8'h33;
    end
  endtask

  task automatic set_yuv(input int base);
    for (int i = 0; i < 4; i++) begin
      r_px[i] = 8'(8'h10 + base + i);
      g_px[i] = 8'(8'h40 + base + i);
      b_px[i] = 8'(8'h80 + base + i);
    end
  endtask

  task automatic raw_two_lines(input logic [1:0] pat);
    tm = 2'd2; bp = pat;
    step(1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
    idle(1);
    step(1'b0, 1'b1, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
    idle(3);
  endtask

  initial begin
    rst = 1'b1; s_vs = 1'b0; s_hs = 1'b0; s_de = 1'b0; tm = 2'd0; bp = 2'd0;
    set_const();
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_outputs", 64'({m_vs4, m_hs4, m_de4, m_mact4, m_data4 != 144'h0}), 64'h0);
    rst = 1'b0;
    idle(2);

    raw_two_lines(2'd0);
    want = '{PR, PG, PR, PG, PR, PG, PR, PG, PG, PB, PG, PB, PG, PB, PG, PB};
    compare_cap("rggb", 1'b0);

    raw_two_lines(2'd3);
    want = '{PB, PG, PB, PG, PB, PG, PB, PG, PG, PR, PG, PR, PG, PR, PG, PR};
    compare_cap("bggr", 1'b0);

    tm = 2'd1; bp = 2'd0;
    step(1'b1, 1'b0, 1'b0);
    idle(1);
    set_yuv(0); step(1'b0, 1'b0, 1'b1);
    set_yuv(3); step(1'b0, 1'b0, 1'b1);
    set_yuv(6); step(1'b0, 1'b0, 1'b1);
    idle(3);
    want = '{36'h000400100, 36'h000800110, 36'h000420120, 36'h000820130, 36'h000440140,
             36'h000840150, 36'h000460160, 36'h000860170, 36'h000480180};
    compare_cap("yuv422_p3", 1'b1);
    check("yuv422_mode_act", 64'(m_mact3), 64'h1);
    set_const();

    tm = 2'd0; bp = 2'd0;
    step(1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b1);
    tm = 2'd2;
    step(1'b0, 1'b0, 1'b1);
    idle(3);
    want = '{PORG, PORG, PORG, PORG, PORG, PORG, PORG, PORG};
    compare_cap("midframe_mode", 1'b0);
    check("midframe_mode_act", 64'(m_mact4), 64'h0);
    step(1'b1, 1'b0, 1'b0);
    idle(2);
    check("next_frame_mode_act", 64'(m_mact4), 64'h2);
    step(1'b0, 1'b0, 1'b1);
    idle(3);
    want = '{PR, PG, PR, PG};
    compare_cap("next_frame_raw", 1'b0);

    tm = 2'd2; bp = 2'd0;
    step(1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b1);
    check("pre_reset_mode_act", 64'(m_mact4), 64'h2);
    check("pre_reset_de", 64'(m_de4), 64'h1);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    check("post_reset_outputs", 64'({m_vs4, m_hs4, m_de4, m_mact4, m_data4 != 144'h0}), 64'h0);
    step(1'b0, 1'b0, 1'b1);
    check("post_reset_blank", 64'({m_de4, m_data4 != 144'h0}), 64'h0);
    step(1'b0, 1'b0, 1'b1);
    check("post_reset_orig_px", 64'(m_data4[35:0]), 64'(PORG));
    check("post_reset_mode_act", 64'(m_mact4), 64'h0);
    idle(3);
    cap4.delete();
    cap3.delete();

    tm = 2'd2; bp = 2'd0;
    step(1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b1);
    idle(1);
    step(1'b0, 1'b1, 1'b0); idle(1);
    step(1'b0, 1'b1, 1'b0); idle(1);
    step(1'b0, 1'b0, 1'b1);
    idle(1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 1'b0, 1'b1);
    idle(3);
    want = '{PR, PG, PR, PG, PG, PB, PG, PB, PR, PG, PR, PG, PR, PG, PR, PG};
    compare_cap("hs_and_vs_priority", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vid_rgb_mosaic_v2.md
Name: vid_rgb_mosaic_v2

Overview:
Parametrised successor to the video-domain RGB/YUV repacker. Converts C_PORT_NUM parallel pixels per clock into one of three layouts:
- pass-through
- YUV444 -> YUV422
- RGB -> Bayer RAW, with a runtime-selectable CFA pattern.

It adds line/column phase tracking that works for odd port counts, frame-aligned shadowing of control inputs, and blanking of data outside DE. It sits between the pattern/input video pipeline and RAW/422 sinks on the single video clock.

Parameters:
C_PORT_NUM, 4, pixels per clock beat (1..8, odd allowed)
C_BITS_IN, 8, bits per input component
C_BITS_PER_CPNT, 12, bits per output component slot (>= C_BITS_IN)
C_MAX_CPNTS_PER_PIXEL, 3, component slots per output pixel (>= 2)

Ports:
VID_CLK  in  1  video clock
VID_RST  in  1  synchronous reset, active-high
S_VS  in  1  vertical sync, active-high
S_HS  in  1  horizontal sync, active-high
S_DE  in  1  data enable
S_R_Y  in  C_BITS_IN*C_PORT_NUM  R or Y, pixel i at [C_BITS_IN*i +: C_BITS_IN]
S_G_U  in  C_BITS_IN*C_PORT_NUM  G or U
S_B_V  in  C_BITS_IN*C_PORT_NUM  B or V
TRANSFER_MODE  in  2  0 original, 1 YUV444->422, 2 RGB->RAW, 3 = original
BAYER_PATTERN  in  2  0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR
M_VS  out  1  S_VS delayed 2 cycles
M_HS  out  1  S_HS delayed 2 cycles
M_DE  out  1  S_DE delayed 2 cycles
M_VID_DATA  out  C_BITS_PER_CPNT*C_MAX_CPNTS_PER_PIXEL*C_PORT_NUM  slot 0 = lowest bits
M_MODE_ACT  out  4  {pattern, mode} currently in effect

Behaviour:
Reset:
- On VID_RST high at a VID_CLK edge, all outputs and internal state clear to 0.
- Reset mid-line drops the line; the first S_VS rise after reset re-arms everything.

Latency and blanking:
- Fixed 2-cycle pipeline: stage 1 registers inputs and phase; stage 2 forms data.
- Sync outputs are delayed to match data.
- When the stage-2 DE is 0, M_VID_DATA = 0.

Component packing:
- Each component is left-aligned in its slot: {value, (C_BITS_PER_CPNT-C_BITS_IN) zeros}.
- Unused slots are 0.

Control shadowing:
- TRANSFER_MODE and BAYER_PATTERN are sampled only on an S_VS rising edge and held for the frame.
- After reset, mode 0 / pattern 0 are in effect until the first VS rise.

Line parity (lp):
- Cleared on the S_VS rising edge.
- Toggles on each S_DE falling edge, i.e. the end of an active line; HS-only lines do not toggle it.
- If VS rises and DE falls in the same cycle, VS wins and lp = 0.

Column parity:
- Pixel i in a beat has parity cp_i = (cph + i) mod 2.
- cph is cleared on the S_DE rising edge.
- cph advances by C_PORT_NUM mod 2 on every DE beat, so for even C_PORT_NUM it stays 0.

Mode 0 / 3:
- Slots 0/1/2 = R_Y / G_U / B_V.

Mode 1 (YUV444 -> 422):
- Slot 0 = Y.
- Slot 1 = U of the pixel itself when cp_i = 0.
- Slot 1 = V of the preceding pixel when cp_i = 1.
- For pixel 0 with cp = 1 (odd port counts), the preceding pixel is the last port of the previous beat. Its V is held in a register, loaded on every DE beat.

Mode 2 (RAW):
- Effective phase (l, c) = (lp ^ BAYER_PATTERN[1], cp_i ^ BAYER_PATTERN[0]).
- (0,0) -> R, (0,1) -> G, (1,0) -> G, (1,1) -> B.
- The result goes in slot 0; other slots are 0.

Boundary cases:
- DE low for one cycle mid-line is treated as a line end: lp toggles and cph clears.
- A mode change is ignored mid-frame; it takes effect on the next VS rise.

Decomposition:
Package vid_mosaic_pkg holds:
- mode encodings MODE_ORIG=0, MODE_YUV422=1, MODE_RAW=2
- pattern encodings PAT_RGGB..PAT_BGGR
- a function that packs a left-aligned slot

One sub-module, vid_edge_det: registered rising/falling edge detector with synchronous active-high reset, instanced for S_VS and S_DE.

Test Plan:
1. C_PORT_NUM=4, mode 2, pattern 0; constant R=0x11, G=0x22, B=0x33; 2 lines of 2 beats -> line 0 slot0 per port = 0x110,0x220,0x110,0x220; line 1 = 0x220,0x330,0x220,0x330; M_DE equals S_DE delayed 2 cycles.
2. Same stimulus, pattern 3 (BGGR) -> line 0 = 0x330,0x220,...; line 1 = 0x220,0x110,...
3. C_PORT_NUM=3, mode 1; Y=0x10+n, U=0x40+n, V=0x80+n for global pixel n -> pixel 3 (beat 1, port 0) slot1 = V of pixel 2 = 0x820; pixel 4 slot1 = U4 = 0x440.
4. TRANSFER_MODE changed from 0 to 2 mid-frame -> output stays mode 0 and M_MODE_ACT is unchanged until the next S_VS rise, after which the RAW layout appears.
5. Assert VID_RST mid-line for 1 cycle -> all outputs 0 the next cycle; lp/cph reset; data stays 0 while the delayed DE is low.
6. S_HS pulses between lines with no DE -> lp does not toggle; VS rise coincident with DE fall -> lp = 0.
